rover_drive_sequencer: RTL and testbench
========================================

Name: rover_drive_sequencer

Overview:
Sequences the rover's 3-bit drive-state bus that feeds the motor controller. Encoding on drive_state[1:0]: 00 stop, 01 right, 10 left, 11 forward; bit 2 is always 0.
Accepts drive commands over a valid/ready handshake and enforces a stop dead-time between direction changes. Also enforces a minimum dwell per manoeuvre and an obstacle-forced halt.
Sits between the navigation logic and the motor controller.

Parameters:
DEAD_CYCLES, 4, stop cycles inserted before any new nonzero drive code; legal range >= 1
MIN_DWELL, 16, cycles a drive code must be held before a new command is accepted in RUN; legal range >= 1
TIMEOUT_CYCLES, 1000, RUN inactivity limit; used only with the optional feature
CNT_W, 16, counter width; must hold the largest of the three count parameters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_code  in  2  requested code: 00 stop, 01 right, 10 left, 11 forward
cmd_ready  out  1  command is accepted on an edge where cmd_valid and cmd_ready are both high
obstacle  in  1  synchronous obstacle flag; high forces a halt
drive_state  out  3  registered code to the motor controller, {1'b0, code}
busy  out  1  high when the FSM is not in IDLE
fault  out  1  sticky halt/timeout indicator

Behaviour:
- Reset (async, immediate): state IDLE, drive_state 000, fault 0, all counters 0. cmd_ready is held 0 while rst is high.
- States: IDLE, DEAD, RUN, HALT. drive_state is 000 in every state except RUN.
- cmd_ready is combinational: it is high when obstacle is 0 AND either (state is IDLE) or (state is RUN and dwell count >= MIN_DWELL). It is 0 in DEAD and in HALT.
- An accepted command clears fault.
- IDLE:
  - Accept 00: remain in IDLE.
  - Accept a nonzero code c: latch pending=c, clear the counter, go to DEAD.
- DEAD:
  - drive_state is 000.
  - Counter increments each cycle; when the counter reaches DEAD_CYCLES-1, go to RUN.
  - Latency: a command accepted at edge N gives drive_state={0,c} after edge N+DEAD_CYCLES.
- RUN:
  - drive_state={0,pending}; the dwell counter increments and saturates at MIN_DWELL.
  - Accept the same code as current: clear the dwell counter; no dead time is inserted.
  - Accept 00: go to IDLE; drive_state is 000 after that edge.
  - Accept a different nonzero code: latch pending, go to DEAD; drive_state is 000 after that edge.
- Obstacle handling:
  - obstacle=1 at an edge in IDLE, DEAD or RUN: go to HALT, drive_state 000, set fault=1, discard pending.
  - HALT: the counter is held at 0 while obstacle=1. Once obstacle=0, count DEAD_CYCLES cycles, then go to IDLE.
  - If obstacle reasserts during that count, the counter restarts.
- Simultaneous cmd_valid and obstacle: obstacle wins. cmd_ready is already 0, so the command is not accepted.
- busy = (state != IDLE).
- Reset asserted mid-manoeuvre: drive_state goes to 000 asynchronously and the pending command is lost.

Optional Feature:
CMD_TIMEOUT_EN
- Defined: an inactivity counter runs in RUN and clears on every accepted command. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, drive_state becomes 000 and fault is set to 1.
- Undefined: RUN holds its code indefinitely; TIMEOUT_CYCLES is ignored and no timeout logic is built.

Test Plan:
- Forward from idle: reset, then accept 11 at edge N -> drive_state stays 000 through N+3 and is 011 after N+4; cmd_ready is 0 until the dwell count reaches 16.
- Direction change: in RUN with 011 after dwell, accept 01 -> drive_state 000 for 4 cycles, then 001; busy stays 1 throughout.
- Early command: in RUN 5 cycles after entry, cmd_valid=1 with code 10 -> cmd_ready=0 and the command is held until the dwell count reaches 16, then accepted.
- Obstacle: in RUN 011, raise obstacle for 3 cycles -> drive_state 000 the next edge, fault=1; IDLE 4 cycles after obstacle falls; a later accepted 11 clears fault.
- Same code and stop: in RUN 010, accept 10 -> no dead gap and the dwell counter restarts; accept 00 -> drive_state 000 next edge, busy=0.
- Async reset: assert rst mid-cycle during RUN 011 -> drive_state 000 immediately without a clock edge. (With CMD_TIMEOUT_EN, TIMEOUT_CYCLES=50: idle in RUN for 50 cycles -> IDLE with fault=1.)

Source files
------------

// File: rtl/rover_drive_sequencer.sv
// -----------------------------------------------------------------------------
// rover_drive_sequencer
//
// Purpose:
//   Sequences the 3-bit drive-state bus that feeds the rover motor controller.
//   Drive codes on drive_state[1:0]: 00 stop, 01 right, 10 left, 11 forward;
//   bit 2 is always 0. Commands arrive over a valid/ready handshake. A stop
//   dead-time is inserted before any new nonzero drive code, every manoeuvre
//   is held for a minimum dwell before a new command is taken, and an
//   obstacle flag forces a halt with a sticky fault indication.
//
// Optional feature (compile-time macro CMD_TIMEOUT_EN):
//   When defined, an inactivity counter runs in RUN and clears on every
//   accepted command; reaching TIMEOUT_CYCLES returns the FSM to IDLE and sets
//   fault. When undefined, RUN holds its code indefinitely and no timeout
//   logic is built.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   cmd_valid    in   1  command offered
//   cmd_code     in   2  requested drive code
//   cmd_ready    out  1  command accepted on an edge with cmd_valid & cmd_ready
//   obstacle     in   1  synchronous obstacle flag, forces a halt
//   drive_state  out  3  registered code to the motor controller, {1'b0, code}
//   busy         out  1  FSM is not in IDLE
//   fault        out  1  sticky halt/timeout indicator
// -----------------------------------------------------------------------------
module rover_drive_sequencer #(
  parameter int DEAD_CYCLES    = 4,
  parameter int MIN_DWELL      = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_code,
  output logic       cmd_ready,
  input  logic       obstacle,
  output logic [2:0] drive_state,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MIN_DWELL);

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_pending;
  logic [1:0]       w_nextPending;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] w_nextDwell;
  logic             r_fault;
  logic             w_nextFault;
  logic [2:0]       r_drive;
  logic [2:0]       w_nextDrive;
  logic             w_accept;

`ifdef CMD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_idleCnt;
  logic [CNT_W-1:0] w_nextIdleCnt;
`endif

  // Ready is combinational so a waiting command is taken on the very edge the
  // dwell expires. It is forced low during reset and whenever an obstacle is
  // present, which is what gives the obstacle priority over a command.
  assign cmd_ready = !rst && !obstacle &&
                     ((r_state == IDLE) ||
                      ((r_state == RUN) && (r_dwell >= DWELL_MAX)));

  assign w_accept    = cmd_valid && cmd_ready;
  assign drive_state = r_drive;
  assign busy        = (r_state != IDLE);
  assign fault       = r_fault;

  // Next-state logic. The obstacle check sits ahead of the per-state case so it
  // overrides anything a state would otherwise do; HALT handles the flag
  // itself because there it restarts the recovery count instead.
  always_comb begin
    w_nextState   = r_state;
    w_nextPending = r_pending;
    w_nextCnt     = r_cnt;
    w_nextDwell   = r_dwell;
    w_nextFault   = r_fault;
`ifdef CMD_TIMEOUT_EN
    w_nextIdleCnt = r_idleCnt;
`endif

    if (w_accept) begin
      w_nextFault = 1'b0;
    end

    if (obstacle && (r_state != HALT)) begin
      w_nextState   = HALT;
      w_nextPending = 2'b00;
      w_nextCnt     = '0;
      w_nextDwell   = '0;
      w_nextFault   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && (cmd_code != 2'b00)) begin
            w_nextPending = cmd_code;
            w_nextCnt     = '0;
            w_nextState   = DEAD;
          end
        end

        DEAD: begin
          if (r_cnt == DEAD_LAST) begin
            w_nextState = RUN;
            w_nextCnt   = '0;
            w_nextDwell = '0;
`ifdef CMD_TIMEOUT_EN
            w_nextIdleCnt = '0;
`endif
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end

        RUN: begin
          if (r_dwell < DWELL_MAX) begin
            w_nextDwell = r_dwell + 1'b1;
          end
`ifdef CMD_TIMEOUT_EN
          w_nextIdleCnt = r_idleCnt + 1'b1;
`endif
          if (w_accept) begin
`ifdef CMD_TIMEOUT_EN
            w_nextIdleCnt = '0;
`endif
            if (cmd_code == 2'b00) begin
              w_nextState   = IDLE;
              w_nextPending = 2'b00;
            end else if (cmd_code == r_pending) begin
              // Re-issuing the current code only restarts the dwell.
              w_nextDwell = '0;
            end else begin
              w_nextPending = cmd_code;
              w_nextCnt     = '0;
              w_nextState   = DEAD;
            end
          end
`ifdef CMD_TIMEOUT_EN
          else if (r_idleCnt == TIMEOUT_LAST) begin
            w_nextState   = IDLE;
            w_nextPending = 2'b00;
            w_nextFault   = 1'b1;
            w_nextIdleCnt = '0;
          end
`endif
        end

        HALT: begin
          if (obstacle) begin
            w_nextCnt = '0;
          end else if (r_cnt == DEAD_LAST) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end

        default: begin
          w_nextState = IDLE;
        end
      endcase
    end

    // The output bus is registered from the next state so it changes on the
    // same edge as the state itself.
    w_nextDrive = (w_nextState == RUN) ? {1'b0, w_nextPending} : 3'b000;
  end

  // State and datapath registers with asynchronous reset so the motor bus
  // drops to stop immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= 2'b00;
      r_cnt     <= '0;
      r_dwell   <= '0;
      r_fault   <= 1'b0;
      r_drive   <= 3'b000;
`ifdef CMD_TIMEOUT_EN
      r_idleCnt <= '0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_pending <= w_nextPending;
      r_cnt     <= w_nextCnt;
      r_dwell   <= w_nextDwell;
      r_fault   <= w_nextFault;
      r_drive   <= w_nextDrive;
`ifdef CMD_TIMEOUT_EN
      r_idleCnt <= w_nextIdleCnt;
`endif
    end
  end

endmodule

// File: tb/tb_rover_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rover_drive_sequencer
//
// Purpose:
//   Self-checking bench for rover_drive_sequencer with default parameters
//   (DEAD_CYCLES=4, MIN_DWELL=16). Directed stimulus pushes hand-computed
//   drive-bus transitions (cycle, code, busy, fault) into a scoreboard queue;
//   a monitor pops an entry every time drive_state changes and compares.
//   Handshake timing and status flags are checked directly at known cycles.
// -----------------------------------------------------------------------------
module tb_rover_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_code = 2'b00;
  logic       cmd_ready;
  logic       obstacle = 1'b0;
  logic [2:0] drive_state;
  logic       busy;
  logic       fault;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int         cycle;
    logic [2:0] drive;
    logic       busy;
    logic       fault;
  } expect_t;

  expect_t    sbQ[$];
  logic [2:0] prevDrive = 3'b000;

  rover_drive_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_ready   (cmd_ready),
    .obstacle    (obstacle),
    .drive_state (drive_state),
    .busy        (busy),
    .fault       (fault)
  );

  // 10 ns clock; cyc counts rising edges since time zero.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Scoreboard monitor: every change on the drive bus must match the oldest
  // expected transition in cycle, code and status flags.
  always @(negedge clk) begin
    if (drive_state !== prevDrive) begin
      checks++;
      if (sbQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb_unexpected: drive %b -> %b at cyc %0d, required no change",
                 prevDrive, drive_state, cyc);
      end else begin
        expect_t e;
        e = sbQ.pop_front();
        if ((cyc != e.cycle) || (drive_state !== e.drive) ||
            (busy !== e.busy) || (fault !== e.fault)) begin
          fails++;
          $display("[TB] FAIL sb_transition: got cyc=%0d drive=%b busy=%b fault=%b, required cyc=%0d drive=%b busy=%b fault=%b",
                   cyc, drive_state, busy, fault, e.cycle, e.drive, e.busy, e.fault);
        end
      end
      prevDrive = drive_state;
    end
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExpect(input int c, input logic [2:0] d, input logic b, input logic f);
    expect_t e;
    e.cycle = c;
    e.drive = d;
    e.busy  = b;
    e.fault = f;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (cyc %0d)", name, actual, required, cyc);
    end
  endtask

  // Returns at the falling edge whose cycle count equals c.
  task automatic waitToCycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // Offers a command from the current falling edge and holds it until the
  // DUT takes it. acceptCyc is the rising edge on which it was accepted.
  task automatic applyStimulus(input logic [1:0] code, output int acceptCyc);
    int waited;
    waited    = 0;
    acceptCyc = -1;
    cmd_valid = 1'b1;
    cmd_code  = code;
    #1;
    while (!cmd_ready && (waited < 100)) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL handshake_timeout: cmd_ready stayed 0, required 1 within 100 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acceptCyc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    int e;
    int d;
    int r;
    int s;
    int a;
    int f;
    int h;
    int g;
    int rc;

    $display("[TB] rover_drive_sequencer bench start");

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_drive", 32'(drive_state), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_fault", 32'(fault), 32'h0);
    checkOutput("reset_ready_low", 32'(cmd_ready), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("idle_ready", 32'(cmd_ready), 32'h1);

    // Forward from idle: 011 appears DEAD_CYCLES edges after acceptance
    @(negedge clk);
    applyStimulus(2'b11, n);
    pushExpect(n + 4, 3'b011, 1'b1, 1'b0);
    e = n + 4;
    waitToCycle(n + 1);
    checkOutput("fwd_dead_drive", 32'(drive_state), 32'h0);
    checkOutput("fwd_dead_busy", 32'(busy), 32'h1);
    checkOutput("fwd_dead_ready", 32'(cmd_ready), 32'h0);
    waitToCycle(e + 15);
    checkOutput("fwd_dwell15_ready", 32'(cmd_ready), 32'h0);
    waitToCycle(e + 16);
    checkOutput("fwd_dwell16_ready", 32'(cmd_ready), 32'h1);
    checkOutput("fwd_run_drive", 32'(drive_state), 32'h3);

    // Direction change 011 -> 001 with a four-cycle stop gap
    pushExpect(e + 17, 3'b000, 1'b1, 1'b0);
    pushExpect(e + 21, 3'b001, 1'b1, 1'b0);
    applyStimulus(2'b01, d);
    checkOutput("dir_accept_cyc", 32'(d), 32'(e + 17));
    for (int i = 0; i < 4; i++) begin
      waitToCycle(d + i);
      checkOutput("dir_gap_busy", 32'(busy), 32'h1);
    end

    // Early command: offered 5 cycles into RUN, taken once dwell reaches 16
    r = d + 4;
    waitToCycle(r + 5);
    pushExpect(r + 17, 3'b000, 1'b1, 1'b0);
    pushExpect(r + 21, 3'b010, 1'b1, 1'b0);
    applyStimulus(2'b10, a);
    checkOutput("early_accept_cyc", 32'(a), 32'(r + 17));

    // Same code restarts dwell without a gap; then stop
    s = r + 21;
    waitToCycle(s + 16);
    applyStimulus(2'b10, a);
    checkOutput("same_accept_cyc", 32'(a), 32'(s + 17));
    waitToCycle(a + 1);
    checkOutput("same_drive_held", 32'(drive_state), 32'h2);
    checkOutput("same_dwell_restart", 32'(cmd_ready), 32'h0);
    pushExpect(a + 17, 3'b000, 1'b0, 1'b0);
    waitToCycle(a + 16);
    applyStimulus(2'b00, rc);
    checkOutput("stop_accept_cyc", 32'(rc), 32'(a + 17));
    waitToCycle(rc + 1);
    checkOutput("stop_busy", 32'(busy), 32'h0);
    checkOutput("stop_ready", 32'(cmd_ready), 32'h1);

    // Obstacle in RUN 011 for three cycles
    applyStimulus(2'b11, f);
    pushExpect(f + 4, 3'b011, 1'b1, 1'b0);
    waitToCycle(f + 6);
    obstacle = 1'b1;
    pushExpect(f + 7, 3'b000, 1'b1, 1'b1);
    #1;
    checkOutput("obs_ready_low", 32'(cmd_ready), 32'h0);
    waitToCycle(f + 7);
    checkOutput("obs_fault", 32'(fault), 32'h1);
    checkOutput("obs_busy", 32'(busy), 32'h1);
    waitToCycle(f + 9);
    obstacle = 1'b0;
    waitToCycle(f + 12);
    checkOutput("obs_halt_busy", 32'(busy), 32'h1);
    waitToCycle(f + 13);
    checkOutput("obs_idle_busy", 32'(busy), 32'h0);
    checkOutput("obs_fault_sticky", 32'(fault), 32'h1);

    // Obstacle and command together in IDLE; obstacle re-asserts mid-count
    obstacle  = 1'b1;
    cmd_valid = 1'b1;
    cmd_code  = 2'b11;
    #1;
    checkOutput("simul_ready_low", 32'(cmd_ready), 32'h0);
    h = f + 14;
    waitToCycle(h);
    cmd_valid = 1'b0;
    obstacle  = 1'b0;
    checkOutput("simul_halt_busy", 32'(busy), 32'h1);
    checkOutput("simul_drive", 32'(drive_state), 32'h0);
    waitToCycle(h + 2);
    obstacle = 1'b1;
    waitToCycle(h + 3);
    obstacle = 1'b0;
    waitToCycle(h + 6);
    checkOutput("restart_halt_busy", 32'(busy), 32'h1);
    waitToCycle(h + 7);
    checkOutput("restart_idle_busy", 32'(busy), 32'h0);

    // A later accepted command clears fault
    applyStimulus(2'b11, g);
    pushExpect(g + 4, 3'b011, 1'b1, 1'b0);
    waitToCycle(g + 1);
    checkOutput("clear_fault", 32'(fault), 32'h0);

    // Asynchronous reset in the middle of RUN 011
    waitToCycle(g + 6);
    @(posedge clk);
    #2;
    pushExpect(cyc, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("async_drive", 32'(drive_state), 32'h0);
    checkOutput("async_busy", 32'(busy), 32'h0);
    checkOutput("async_ready", 32'(cmd_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_ready", 32'(cmd_ready), 32'h1);
    checkOutput("post_reset_drive", 32'(drive_state), 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("sb_queue_drained", 32'(sbQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
